// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, RV32I width codes and alignment rule for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/align_check.sv
// rtl/align_check.sv - combinational misalignment detector for one requester
module align_check
  import mem_arb_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  assign misaligned = is_misaligned(funct3, addr_lo);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter in front of one single-port unified memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_en,
  output logic        m_we,
  output logic [2:0]  m_funct3,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       err_q, err_d;
  logic       we_q, we_d;

  logic if_mis, d_mis;
  logic arb_ok, resp, grant_f, grant_d;

  align_check u_if_align (
    .funct3     (F3_W),
    .addr_lo    (if_addr[1:0]),
    .misaligned (if_mis)
  );

  align_check u_d_align (
    .funct3     (d_funct3),
    .addr_lo    (d_addr[1:0]),
    .misaligned (d_mis)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      starve_q <= 4'd0;
      owner_q  <= OWN_FETCH;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      we_q     <= we_d;
    end
  end

  // The last BUSY cycle doubles as an arbitration slot so grants can run back to back.
  always_comb begin
    arb_ok   = (state_q == ST_IDLE) || (cnt_q == LAT);
    resp     = (state_q == ST_BUSY) && (cnt_q == LAT);
    grant_d  = arb_ok && d_req && (!if_req || (starve_q != SMAX));
    grant_f  = arb_ok && if_req && !grant_d;
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    err_d    = err_q;
    we_d     = we_q;
    if (grant_f || grant_d) begin
      state_d = ST_BUSY;
      cnt_d   = 3'd1;
      owner_d = grant_d ? OWN_DATA : OWN_FETCH;
      err_d   = grant_d ? d_mis : if_mis;
      we_d    = grant_d && d_we;
    end else if (resp) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + 3'd1;
    end
    if (grant_f) begin
      starve_d = 4'd0;
    end else if (grant_d) begin
      if (!if_req)               starve_d = 4'd0;
      else if (starve_q != SMAX) starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_err    = 1'b0;
    d_err     = 1'b0;
    if_rdata  = 32'd0;
    d_rdata   = 32'd0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_funct3  = 3'd0;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    if (rst_n) begin
      if_gnt    = grant_f;
      d_gnt     = grant_d;
      if_rvalid = resp && (owner_q == OWN_FETCH);
      d_rvalid  = resp && (owner_q == OWN_DATA);
      if_err    = if_rvalid && err_q;
      d_err     = d_rvalid && err_q;
      if_rdata  = (if_rvalid && !err_q) ? m_rdata : 32'd0;
      d_rdata   = (d_rvalid && !err_q && !we_q) ? m_rdata : 32'd0;
      // Misaligned winners still occupy the slot but never touch the memory.
      if (grant_f && !if_mis) begin
        m_en     = 1'b1;
        m_funct3 = F3_W;
        m_addr   = if_addr;
      end else if (grant_d && !d_mis) begin
        m_en     = 1'b1;
        m_we     = d_we;
        m_funct3 = d_funct3;
        m_addr   = d_addr;
        m_wdata  = d_wdata;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared single-port unified memory between the core's instruction-fetch path and its load/store path, so the instruction memory and data memory can merge into one array. Sits between the core datapath (PC / fetch and the data-memory controller interface) and the memory macro. One transaction is outstanding at a time. Read data returns after a fixed latency. Misaligned accesses are flagged, not issued.

## Interface
- MEM_LAT, 1: cycles from issue (m_en high) to valid m_rdata; legal range 1-7.
- STARVE_MAX, 4: consecutive data grants, taken while fetch is waiting, after which fetch wins the next contested arbitration; legal range 1-15.
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  one-cycle pulse; fetch issued this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata / if_err valid.
- if_rdata  out  32  fetched instruction; 0 when if_err.
- if_err  out  1  if_addr[1:0] != 0; qualified by if_rvalid.
- d_req  in  1  data request; held with d_we, d_funct3, d_addr, d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  one-cycle pulse; data access issued this cycle.
- d_rvalid  out  1  one-cycle pulse; completion. Asserted for stores too.
- d_rdata  out  32  load data from memory; 0 for stores or when d_err.
- d_err  out  1  misaligned (half-word with addr[0] set, word with addr[1:0] != 0); qualified by d_rvalid.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_funct3  out  3  width code forwarded to memory.
- m_addr  out  32  memory byte address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid MEM_LAT cycles after m_en.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY: latency counter `cnt` runs 1..MEM_LAT.
  - Registered `owner` (FETCH/DATA) and `err_q` are captured at grant.
- Arbitration happens in IDLE, or in the last BUSY cycle (cnt == MEM_LAT).
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless `starve` == STARVE_MAX, in which case grant fetch.
- `starve` counter:
  - Increments on a data grant while if_req is high.
  - Clears on any fetch grant, or on a data grant while if_req is low.
  - Saturates at STARVE_MAX.
- Grant cycle:
  - The gnt pulse for the winner.
  - The winner's addr/funct3/wdata/we are driven on m_*.
  - m_en = 1 only if the access is aligned; a misaligned access consumes the same latency with m_en = 0.
  - Next state is BUSY with cnt = 1.
- Response cycle (cnt == MEM_LAT):
  - The owner's rvalid pulses.
  - rdata is driven combinationally from m_rdata (gated to 0 for store or err).
  - err = err_q.
  - Next state is BUSY with cnt = 1 if a new grant happens in the same cycle, otherwise IDLE.
- Fetch requests are always reads. m_funct3 = LW for fetch.
- When m_en = 0, m_* outputs are driven to 0.

## Timing
- Latency: grant at cycle T, rvalid at cycle T+MEM_LAT.
- Peak throughput: one transaction per MEM_LAT cycles. With MEM_LAT = 1, back-to-back grants every cycle.
- Grant is combinational from req and state. The requester may change its request fields the cycle after gnt.
- Reset (rst_n low at a posedge) sets state IDLE, cnt 0, starve 0, owner FETCH, err_q 0.
- While rst_n is low, all outputs are forced to 0 combinationally.
- Reset mid-transaction: the pending response is dropped, and no rvalid follows.
- A requester must not drop req before gnt; behaviour if it does is undefined. The bench must not do this.
- if_gnt and d_gnt are never high in the same cycle. Likewise if_rvalid and d_rvalid.

## Structure
- Package `mem_arb_pkg`:
  - State enum (IDLE/BUSY).
  - Owner enum.
  - RV32I funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
  - Function `is_misaligned(funct3, addr[1:0])`.
- One sub-module `align_check`: a combinational misalignment detector, instanced twice (fetch with F3_W, data with d_funct3).
- The arbiter FSM, counters and muxing live in the top module.

## Test plan
- MEM_LAT=2; if_req, if_addr=0x10, m_rdata=0x00500093 -> if_gnt at T, m_en=1, m_addr=0x10, if_rvalid at T+2, if_rdata=0x00500093, if_err=0.
- MEM_LAT=1; d_req store SW addr=0x100 wdata=0xDEADBEEF -> d_gnt, m_we=1, m_wdata=0xDEADBEEF; next cycle d_rvalid=1, d_rdata=0.
- MEM_LAT=1, STARVE_MAX=4; if_req and d_req held high continuously -> grant order D,D,D,D,F,D,D,D,D,F.
- d_req LH addr=0x203 -> d_gnt, m_en=0 throughout; after MEM_LAT cycles d_rvalid=1, d_err=1, d_rdata=0. Likewise if_addr=0x06 -> if_err=1.
- MEM_LAT=3; fetch granted, rst_n low at T+1 for one cycle -> no if_rvalid; all outputs 0 during reset; next if_req granted the cycle after rst_n rises.
- MEM_LAT=2; d_req pending at the response cycle of a fetch -> if_rvalid and d_gnt in the same cycle, d_rvalid two cycles later.
